// File: rtl/uart_rcv.sv
// Oversampling 8N1 UART receiver with four-phase Req/Ack byte handoff.
// Optional even parity bit (8E1) when UART_RCV_PARITY_EN is defined.
module uart_rcv #(
   parameter int OVERSAMPLE = 8
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       RxIn,
   input  logic       Ack,
   output logic [7:0] char,
   output logic       Req,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_RCV_PARITY_EN
      RX_PAR,
`endif
      RX_STOP,
      RX_BREAK
   } rx_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_REQ,
      HS_WAIT
   } hs_t;

   rx_t          rx;
   hs_t          hs;
   logic         s1, rxs;
   logic [CW-1:0] cnt;
   logic [2:0]   bitcnt;
   logic [7:0]   shreg;
   logic         tick;
   logic         bad_par;
   logic         done;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1  <= 1'b1;
         rxs <= 1'b1;
      end else begin
         s1  <= RxIn;
         rxs <= s1;
      end
   end

   assign tick = (cnt == LAST);

`ifdef UART_RCV_PARITY_EN
   logic par;
   logic pe_q;

   assign bad_par    = (par != ^shreg);
   assign parity_err = pe_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         par  <= 1'b0;
         pe_q <= 1'b0;
      end else begin
         pe_q <= 1'b0;
         if (rx == RX_PAR && tick)
            par <= rxs;
         if (rx == RX_STOP && tick && rxs && bad_par)
            pe_q <= 1'b1;
      end
   end
`else
   assign bad_par    = 1'b0;
   assign parity_err = 1'b0;
`endif

   // good stop bit (and parity) completes the byte this cycle
   assign done = (rx == RX_STOP) && tick && rxs && !bad_par;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rx        <= RX_IDLE;
         cnt       <= '0;
         bitcnt    <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         unique case (rx)
            RX_IDLE: begin
               cnt <= '0;
               if (!rxs) begin
                  rx     <= RX_START;
                  bitcnt <= '0;
               end
            end
            RX_START: begin
               if (cnt == HALF) begin
                  cnt <= '0;
                  rx  <= rxs ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (tick) begin
                  cnt    <= '0;
                  shreg  <= {rxs, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7)
`ifdef UART_RCV_PARITY_EN
                     rx <= RX_PAR;
`else
                     rx <= RX_STOP;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RCV_PARITY_EN
            RX_PAR: begin
               if (tick) begin
                  cnt <= '0;
                  rx  <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (tick) begin
                  cnt <= '0;
                  if (!rxs) begin
                     frame_err <= 1'b1;
                     rx        <= RX_BREAK;
                  end else begin
                     rx <= RX_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_BREAK: begin
               cnt <= '0;
               if (rxs)
                  rx <= RX_IDLE;
            end
            default: rx <= RX_IDLE;
         endcase
      end
   end

   // acceptance only from a handshake that is already idle
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hs      <= HS_IDLE;
         char    <= 8'h00;
         Req     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= done && (hs != HS_IDLE);
         unique case (hs)
            HS_IDLE: begin
               if (done) begin
                  char <= shreg;
                  Req  <= 1'b1;
                  hs   <= HS_REQ;
               end
            end
            HS_REQ: begin
               if (Ack) begin
                  Req <= 1'b0;
                  hs  <= HS_WAIT;
               end
            end
            HS_WAIT: begin
               if (!Ack)
                  hs <= HS_IDLE;
            end
            default: hs <= HS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rcv.sv
// Scoreboard bench for uart_rcv: frames in, bytes popped on each Req rise.
// Parity cases enabled with UART_RCV_PARITY_EN.
module tb_uart_rcv;

   localparam int OS = 8;
`ifdef UART_RCV_PARITY_EN
   localparam int NB  = 11;
   localparam int LAT = 87;
   localparam int EXP_PE = 1;
`else
   localparam int NB  = 10;
   localparam int LAT = 79;
   localparam int EXP_PE = 0;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       RxIn;
   logic       Ack;
   logic [7:0] char;
   logic       Req;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   uart_rcv #(.OVERSAMPLE(OS)) dut (
      .clk        (clk),
      .clr        (clr),
      .RxIn       (RxIn),
      .Ack        (Ack),
      .char       (char),
      .Req        (Req),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_req   = 0;
   int rise_cyc = 0;
   int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
   bit auto_ack = 1'b1;
   logic reqq = 1'b0;
   logic [7:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      if (Req === 1'b1 && reqq !== 1'b1) begin
         n_req++;
         rise_cyc = cyc;
         if (sb.size() == 0)
            chk("unexpected_req", {24'h0, char}, 32'hffff_ffff);
         else
            chk("char", {24'h0, char}, {24'h0, sb.pop_front()});
      end
      reqq <= Req;
   end

   // consumer: Ack two cycles after Req, drop Ack once Req falls
   initial begin
      Ack = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_ack && Req === 1'b1) begin
            repeat (2) @(negedge clk);
            Ack = 1'b1;
            @(negedge clk);
            chk("req_fall", {31'h0, Req}, 32'h0);
            Ack = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic stopb,
                       input logic parb, output int tf);
      logic [10:0] bits;
`ifdef UART_RCV_PARITY_EN
      bits = {stopb, parb, d, 1'b0};
`else
      bits = {parb, stopb, d, 1'b0};
`endif
      @(posedge clk); #1;
      tf = cyc;
      for (int i = 0; i < NB; i++) begin
         RxIn = bits[i];
         repeat (OS) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_req(input int base);
      int k = 0;
      while (n_req == base && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (n_req == base)
         chk("req_timeout", 32'h0, 32'h1);
   endtask

   task automatic wait_hs_idle();
      int k = 0;
      while ((Req === 1'b1 || Ack === 1'b1) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100)
         chk("hs_timeout", 32'h0, 32'h1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_char"}, {24'h0, char}, 32'h0);
      chk({pfx, "_req"}, {31'h0, Req}, 32'h0);
      chk({pfx, "_fe"}, {31'h0, frame_err}, 32'h0);
      chk({pfx, "_ov"}, {31'h0, overrun}, 32'h0);
      chk({pfx, "_pe"}, {31'h0, parity_err}, 32'h0);
   endtask

   initial begin
      int tf, base, fe0, pe0;
      clr  = 1'b1;
      RxIn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst");
      clr = 1'b0;
      repeat (5) @(posedge clk);

      // nominal byte with latency check
      base = n_req;
      sb.push_back(8'hA5);
      send(8'hA5, 1'b1, ^8'hA5, tf);
      RxIn = 1'b1;
      wait_req(base);
      chk("req_latency", rise_cyc - tf, LAT);
      wait_hs_idle();
      chk("nom_no_err", fe_cnt + ov_cnt + pe_cnt, 0);

      // glitch
      @(posedge clk); #1;
      RxIn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      RxIn = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("glitch_req", {31'h0, Req}, 32'h0);
      chk("glitch_flags", fe_cnt + ov_cnt + pe_cnt, 0);

      // framing error, line held low then good byte
      fe0 = fe_cnt;
      send(8'h3C, 1'b0, ^8'h3C, tf);
      repeat (30) @(posedge clk);
      #1;
      RxIn = 1'b1;
      repeat (10) @(posedge clk);
      chk("frame_err_cnt", fe_cnt - fe0, 1);
      chk("frame_no_req", {31'h0, Req}, 32'h0);
      base = n_req;
      sb.push_back(8'h11);
      send(8'h11, 1'b1, ^8'h11, tf);
      RxIn = 1'b1;
      wait_req(base);
      wait_hs_idle();

      // overrun with Ack held low
      auto_ack = 1'b0;
      base = n_req;
      sb.push_back(8'h01);
      send(8'h01, 1'b1, ^8'h01, tf);
      send(8'h02, 1'b1, ^8'h02, tf);
      RxIn = 1'b1;
      repeat (4) @(negedge clk);
      chk("ovr_char", {24'h0, char}, 32'h01);
      chk("ovr_req", {31'h0, Req}, 32'h1);
      chk("ovr_cnt", ov_cnt, 1);
      chk("ovr_one_req", n_req - base, 1);
      auto_ack = 1'b1;
      wait_hs_idle();

      // reset during data bit 4 of 0xFF
      @(posedge clk); #1;
      RxIn = 1'b0;
      repeat (OS) begin
         @(posedge clk); #1;
      end
      RxIn = 1'b1;
      repeat (4 * OS + OS / 2) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      #1;
      check_zero("midrst");
      @(posedge clk); #1;
      clr = 1'b0;
      repeat (20) @(posedge clk);
      base = n_req;
      sb.push_back(8'h5A);
      send(8'h5A, 1'b1, ^8'h5A, tf);
      RxIn = 1'b1;
      wait_req(base);
      chk("post_rst_latency", rise_cyc - tf, LAT);
      wait_hs_idle();

`ifdef UART_RCV_PARITY_EN
      pe0 = pe_cnt;
      send(8'h03, 1'b1, 1'b1, tf);
      RxIn = 1'b1;
      repeat (10) @(posedge clk);
      chk("par_err_cnt", pe_cnt - pe0, 1);
      chk("par_no_req", {31'h0, Req}, 32'h0);
      base = n_req;
      sb.push_back(8'h03);
      send(8'h03, 1'b1, 1'b0, tf);
      RxIn = 1'b1;
      wait_req(base);
      wait_hs_idle();
`else
      pe0 = pe_cnt;
      chk("par_tied", pe0, 0);
`endif

      repeat (20) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("fe_total", fe_cnt, 1);
      chk("ov_total", ov_cnt, 1);
      chk("pe_total", pe_cnt, EXP_PE);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
